// File: rtl/dm_access_ctrl.sv
// MEM-stage load/store sequencer for a variable-latency data memory.
// Builds byte enables and lane-replicated store data, extends load results, and flags misalignment and timeouts.
module dm_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        addr_err_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [1:0]  lo_q, lo_d;
    logic        done_q, done_d;
    logic        aerr_q, aerr_d;
    logic        berr_q, berr_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lo[0];
            2'b10:   bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_repl(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] r;
        case (size)
            2'b00:   r = {4{wd[7:0]}};
            2'b01:   r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extract(input logic [1:0] size, input logic sgn,
                                            input logic [1:0] lo, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // State and datapath registers; reset drops mem_req immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            sgn_q       <= 1'b0;
            lo_q        <= 2'b00;
            done_q      <= 1'b0;
            aerr_q      <= 1'b0;
            berr_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            lo_q        <= lo_d;
            done_q      <= done_d;
            aerr_q      <= aerr_d;
            berr_q      <= berr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // Next-state logic; completion pulses are registered on entry to DONE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        lo_d        = lo_q;
        done_d      = 1'b0;
        aerr_d      = 1'b0;
        berr_d      = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    we_d   = req_we_i;
                    size_d = req_size_i;
                    sgn_d  = req_signed_i;
                    lo_d   = req_addr_i[1:0];
                    if (misaligned(req_size_i, req_addr_i[1:0])) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        aerr_d  = 1'b1;
                    end else begin
                        state_d     = ST_WAIT;
                        cnt_d       = 8'd0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we_i;
                        mem_addr_d  = {req_addr_i[31:2], 2'b00};
                        mem_be_d    = byte_en(req_size_i, req_addr_i[1:0]);
                        mem_wdata_d = lane_repl(req_size_i, req_wdata_i);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // A response on the final allowed cycle wins over the timeout.
                if (mem_ready_i) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = extract(size_q, sgn_q, lo_q, mem_rdata_i);
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    berr_d    = 1'b1;
                    mem_req_d = 1'b0;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                cnt_d   = 8'd0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = 8'd0;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign stall_o     = ((state_q == ST_IDLE) && req_valid_i) || (state_q == ST_WAIT);
    assign done_o      = done_q;
    assign addr_err_o  = aerr_q;
    assign bus_err_o   = berr_q;
    assign rdata_o     = rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_be_o    = mem_be_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl: a driver issues random and directed ops, a memory model answers,
// and a monitor checks every completion against a reference computed from the access rules.
module tb_dm_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done, addr_err, bus_err;
    logic [31:0] rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    dm_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .reset_i(rst),
        .req_valid_i(req_valid), .req_we_i(req_we), .req_size_i(req_size),
        .req_signed_i(req_signed), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .stall_o(stall), .done_o(done), .rdata_o(rdata),
        .addr_err_o(addr_err), .bus_err_o(bus_err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        aerr;
        logic        berr;
        int          dcyc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] word;
    } plan_t;

    exp_t        expq[$];
    plan_t       planq[$];
    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    logic        mem_auto = 1'b1;
    logic [31:0] last_rdata = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Completion monitor: pops the scoreboard on every done pulse.
    always @(posedge clk) begin
        #1;
        if (!rst && done) begin
            if (expq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got done with empty scoreboard (t=%0t)", $time);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("rdata", rdata, e.rdata);
                chk("addr_err", {31'd0, addr_err}, {31'd0, e.aerr});
                chk("bus_err", {31'd0, bus_err}, {31'd0, e.berr});
                chk("done_cycle", cyc, e.dcyc);
                chk("stall_in_done", {31'd0, stall}, 32'd0);
            end
        end
    end

    // Memory model: answers each request after its planned latency and checks the request fields.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (!rst && mem_auto && mem_req) begin
                if (planq.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_mem_req: got mem_req=1 for an op expecting none (t=%0t)", $time);
                    for (int n = 0; n < 4 * TO + 8 && mem_req; n++) begin
                        @(posedge clk); #1;
                    end
                end else begin
                    plan_t p;
                    int k;
                    p = planq.pop_front();
                    chk("mem_we", {31'd0, mem_we}, {31'd0, p.we});
                    chk("mem_addr", mem_addr, p.addr);
                    chk("mem_be", {28'd0, mem_be}, {28'd0, p.be});
                    if (p.we) chk("mem_wdata", mem_wdata, p.wdata);
                    k = 0;
                    mem_ready = (p.lat == 0);
                    mem_rdata = (p.lat == 0) ? p.word : $urandom;
                    forever begin
                        @(posedge clk); #1;
                        if (mem_ready) begin
                            mem_ready = 1'b0;
                            chk("mem_req_drop", {31'd0, mem_req}, 32'd0);
                            break;
                        end else if (k + 1 == TO) begin
                            chk("mem_req_timeout_drop", {31'd0, mem_req}, 32'd0);
                            break;
                        end else begin
                            chk("mem_req_held", {31'd0, mem_req}, 32'd1);
                            chk("mem_addr_stable", mem_addr, p.addr);
                            if (!mem_req) break;
                            k++;
                            mem_ready = (k == p.lat);
                            mem_rdata = (k == p.lat) ? p.word : $urandom;
                        end
                    end
                    mem_rdata = $urandom;
                end
            end
        end
    end

    // Reference model plus driver for one op; called at posedge+1 with the DUT idle.
    task automatic do_op(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int lat, input logic [31:0] word);
        logic [1:0]  lo;
        logic        bad;
        exp_t        e;
        plan_t       p;
        logic [31:0] sh;
        lo  = addr[1:0];
        bad = (size == 2'd3) || (size == 2'd1 && lo[0]) || (size == 2'd2 && lo != 2'd0);
        e.aerr = bad;
        e.berr = 1'b0;
        if (bad) begin
            e.dcyc = cyc + 1;
        end else begin
            p.we   = we;
            p.addr = addr & 32'hFFFF_FFFC;
            p.be   = (size == 2'd0) ? 4'(1 << lo) : (size == 2'd1) ? 4'(3 << lo) : 4'hF;
            p.wdata = (size == 2'd0) ? 32'h0101_0101 * (wdata & 32'hFF)
                    : (size == 2'd1) ? 32'h0001_0001 * (wdata & 32'hFFFF) : wdata;
            p.lat  = lat;
            p.word = word;
            planq.push_back(p);
            if (lat < TO) begin
                e.dcyc = cyc + lat + 2;
                if (!we) begin
                    sh = word >> (8 * lo);
                    if (size == 2'd0) begin
                        last_rdata = sh & 32'hFF;
                        if (sgn && last_rdata >= 32'h80) last_rdata = last_rdata | 32'hFFFF_FF00;
                    end else if (size == 2'd1) begin
                        last_rdata = sh & 32'hFFFF;
                        if (sgn && last_rdata >= 32'h8000) last_rdata = last_rdata | 32'hFFFF_0000;
                    end else begin
                        last_rdata = word;
                    end
                end
            end else begin
                e.dcyc = cyc + TO + 1;
                e.berr = 1'b1;
            end
        end
        e.rdata = last_rdata;
        expq.push_back(e);
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        #1;
        chk("stall_on_issue", {31'd0, stall}, 32'd1);
        begin
            int n;
            for (n = 0; n < 3 * TO + 10; n++) begin
                @(posedge clk); #1;
                if (done) break;
            end
            if (n == 3 * TO + 10) begin
                checks++;
                $display("FAIL done_timeout: got no done within %0d cycles", n);
            end
        end
        req_valid = 1'b0;
        req_addr  = $urandom;
        @(posedge clk); #1;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'd0, 0, 32'h80FF_1234);
        do_op(1'b0, 2'd1, 1'b0, 32'h0000_0012, 32'd0, 2, 32'hBEEF_0000);
        do_op(1'b1, 2'd0, 1'b0, 32'h0000_0021, 32'h0000_00A5, 1, 32'd0);
        do_op(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'd0, 0, 32'd0);
        do_op(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'd0, 0, 32'd0);
        do_op(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, TO + 1, 32'h1234_5678);
        do_op(1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'd0, TO - 1, 32'hCAFE_F00D);

        for (int i = 0; i < 150; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            int          l;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            l = ($urandom_range(0, 4) == 0) ? $urandom_range(0, TO + 1) : $urandom_range(0, 2);
            do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, l, $urandom);
        end

        // Reset in the second WAIT cycle: request dropped at once, no completion.
        mem_auto = 1'b0;
        req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h0000_0040;
        req_valid = 1'b1;
        for (int n = 0; n < 8 && !mem_req; n++) begin
            @(posedge clk); #1;
        end
        chk("rstwait_mem_req_up", {31'd0, mem_req}, 32'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rstwait_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rstwait_done", {31'd0, done}, 32'd0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstwait_done_after", {31'd0, done}, 32'd0);
        last_rdata = 32'd0;
        chk("rstwait_rdata", rdata, 32'd0);
        rst = 1'b0;
        mem_auto = 1'b1;
        @(posedge clk); #1;
        do_op(1'b0, 2'd1, 1'b1, 32'h0000_0042, 32'd0, 1, 32'h8001_7FFF);

        for (int n = 0; n < 20 && expq.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        if (expq.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", expq.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
